press_event_decoder: RTL

PRESS_EVENT_DECODER -- requirements
Module: press_event_decoder

---
 rtl/press_event_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/press_event_decoder.sv
// Button press decoder: short/long press pulses, optional auto-repeat, press counter.
// Define PRESS_AUTOREPEAT_EN to build the auto-repeat counter and repeat_press pulses.
module press_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       en,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_press,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_REL, IDLE, PRESS, LONG} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   hold_cnt, hold_cnt_n;
  logic            short_n, long_n, repeat_n, held_n;
  logic [7:0]      press_cnt_n;
`ifdef PRESS_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0]   rep_cnt, rep_cnt_n;
`endif

  always_comb begin
    state_n     = state;
    hold_cnt_n  = hold_cnt;
    short_n     = 1'b0;
    long_n      = 1'b0;
    repeat_n    = 1'b0;
    press_cnt_n = press_cnt;
`ifdef PRESS_AUTOREPEAT_EN
    rep_cnt_n   = rep_cnt;
`endif
    if (!en) begin
      state_n    = WAIT_REL;
      hold_cnt_n = '0;
`ifdef PRESS_AUTOREPEAT_EN
      rep_cnt_n  = '0;
`endif
    end else begin
      unique case (state)
        WAIT_REL: begin
          if (!btn) state_n = IDLE;
        end
        IDLE: begin
          if (btn) begin
            state_n    = PRESS;
            hold_cnt_n = CW'(1);
          end
        end
        PRESS: begin
          if (btn) begin
            if (hold_cnt == HOLD_LAST) begin
              state_n     = LONG;
              hold_cnt_n  = '0;
              long_n      = 1'b1;
              press_cnt_n = press_cnt + 8'd1;
`ifdef PRESS_AUTOREPEAT_EN
              rep_cnt_n   = '0;
`endif
            end else begin
              hold_cnt_n = hold_cnt + CW'(1);
            end
          end else begin
            state_n     = IDLE;
            hold_cnt_n  = '0;
            short_n     = 1'b1;
            press_cnt_n = press_cnt + 8'd1;
          end
        end
        LONG: begin
          if (!btn) begin
            state_n    = IDLE;
            hold_cnt_n = '0;
`ifdef PRESS_AUTOREPEAT_EN
            rep_cnt_n  = '0;
`endif
          end else begin
`ifdef PRESS_AUTOREPEAT_EN
            if (rep_cnt == REP_LAST) begin
              repeat_n  = 1'b1;
              rep_cnt_n = '0;
            end else begin
              rep_cnt_n = rep_cnt + CW'(1);
            end
`endif
          end
        end
        default: state_n = WAIT_REL;
      endcase
    end
    // held is registered from the next state so it tracks the state register exactly
    held_n = (state_n == PRESS) || (state_n == LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_REL;
      hold_cnt     <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      held         <= 1'b0;
      press_cnt    <= '0;
`ifdef PRESS_AUTOREPEAT_EN
      rep_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_cnt_n;
      short_press  <= short_n;
      long_press   <= long_n;
      repeat_press <= repeat_n;
      held         <= held_n;
      press_cnt    <= press_cnt_n;
`ifdef PRESS_AUTOREPEAT_EN
      rep_cnt      <= rep_cnt_n;
`endif
    end
  end

endmodule
